// File: rtl/lcd_reg_reader.sv
// lcd_reg_reader: issues one 8080-style command write (RS=0), then rd_len
// parallel-bus read cycles (RS=1, RD strobed), streaming each captured word
// out with a one-cycle rd_valid pulse. All outputs are registered.
// Optional build macro: LCD_RD_DUMMY_SKIP_EN. When defined, the first bus
// read after the command is a dummy read. It still runs with full timing,
// but it is neither reported nor captured.
// Phase counters are 8 bits wide, so each *_CYC parameter must be <= 256.
module lcd_reg_reader #(
    parameter int WR_LOW_CYC  = 2,
    parameter int WR_HIGH_CYC = 2,
    parameter int TURN_CYC    = 2,
    parameter int RD_LOW_CYC  = 4,
    parameter int RD_HIGH_CYC = 4,
    parameter int LEN_W       = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req,
    input  logic [15:0]      cmd,
    input  logic [LEN_W-1:0] rd_len,
    output logic             busy,
    output logic             done,
    output logic             rd_valid,
    output logic [15:0]      rd_data,
    output logic             LCD_CS,
    output logic             LCD_RS,
    output logic             LCD_WR,
    output logic             LCD_RD,
    output logic [15:0]      LCD_DATA_O,
    output logic             LCD_DATA_OE,
    input  logic [15:0]      LCD_DATA_I
);

    localparam int CYC_W = 8;

    localparam logic [CYC_W-1:0] WR_LOW_LAST  = CYC_W'(WR_LOW_CYC - 1);
    localparam logic [CYC_W-1:0] WR_HIGH_LAST = CYC_W'(WR_HIGH_CYC - 1);
    localparam logic [CYC_W-1:0] TURN_LAST    = CYC_W'(TURN_CYC - 1);
    localparam logic [CYC_W-1:0] RD_LOW_LAST  = CYC_W'(RD_LOW_CYC - 1);
    localparam logic [CYC_W-1:0] RD_HIGH_LAST = CYC_W'(RD_HIGH_CYC - 1);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_CMD_SETUP   = 3'd1;
    localparam logic [2:0] S_CMD_WR_LOW  = 3'd2;
    localparam logic [2:0] S_CMD_WR_HIGH = 3'd3;
    localparam logic [2:0] S_TURN        = 3'd4;
    localparam logic [2:0] S_RD_LOW      = 3'd5;
    localparam logic [2:0] S_RD_HIGH     = 3'd6;
    localparam logic [2:0] S_FINISH      = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [15:0]      cmd_q, cmd_d;
    logic             phase_last;
    logic             capture;
    logic             report;

    logic             cs_q, cs_d, rs_q, rs_d, wr_q, wr_d, rd_q, rd_d;
    logic             oe_q, oe_d, busy_q, busy_d, done_q, done_d;
    logic             rd_valid_q, rd_valid_d;
    logic [15:0]      dout_q, dout_d, rd_data_q, rd_data_d;

    // Flag the final cycle of the current timed phase
    always_comb begin
        phase_last = 1'b1;
        case (state_q)
            S_CMD_WR_LOW:  phase_last = (cyc_q == WR_LOW_LAST);
            S_CMD_WR_HIGH: phase_last = (cyc_q == WR_HIGH_LAST);
            S_TURN:        phase_last = (cyc_q == TURN_LAST);
            S_RD_LOW:      phase_last = (cyc_q == RD_LOW_LAST);
            S_RD_HIGH:     phase_last = (cyc_q == RD_HIGH_LAST);
            default:       phase_last = 1'b1;
        endcase
    end

    // Sequence the command write and read cycles; the read count is compared before it increments so it never wraps
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q + 1'b1;
        len_d    = len_q;
        cmd_d    = cmd_q;
        rd_cnt_d = rd_cnt_q;
        capture  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cyc_d = '0;
                if (req) begin
                    state_d  = S_CMD_SETUP;
                    cmd_d    = cmd;
                    len_d    = rd_len;
                    rd_cnt_d = '0;
                end
            end
            S_CMD_SETUP: begin
                state_d = S_CMD_WR_LOW;
                cyc_d   = '0;
            end
            S_CMD_WR_LOW: begin
                if (phase_last) begin
                    state_d = S_CMD_WR_HIGH;
                    cyc_d   = '0;
                end
            end
            S_CMD_WR_HIGH: begin
                if (phase_last) begin
                    state_d = (len_q == '0) ? S_FINISH : S_TURN;
                    cyc_d   = '0;
                end
            end
            S_TURN: begin
                if (phase_last) begin
                    state_d = S_RD_LOW;
                    cyc_d   = '0;
                end
            end
            S_RD_LOW: begin
                if (phase_last) begin
                    state_d = S_RD_HIGH;
                    cyc_d   = '0;
                    capture = 1'b1;
                end
            end
            S_RD_HIGH: begin
                if (phase_last) begin
                    cyc_d = '0;
                    if (({1'b0, rd_cnt_q} + (LEN_W + 1)'(1)) < {1'b0, len_q}) begin
                        state_d  = S_RD_LOW;
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                cyc_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = '0;
            end
        endcase
    end

    // Decide whether a completed bus read is reported to the consumer
    always_comb begin
`ifdef LCD_RD_DUMMY_SKIP_EN
        report = capture && (rd_cnt_q != '0);
`else
        report = capture;
`endif
    end

    // Derive next bus/status outputs from the next state so every output is a flop aligned with its state
    always_comb begin
        cs_d       = 1'b1;
        rs_d       = 1'b1;
        wr_d       = 1'b1;
        rd_d       = 1'b1;
        oe_d       = 1'b0;
        dout_d     = '0;
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_FINISH);
        rd_valid_d = report;
        rd_data_d  = report ? LCD_DATA_I : rd_data_q;
        case (state_d)
            S_CMD_SETUP, S_CMD_WR_HIGH: begin
                cs_d   = 1'b0;
                rs_d   = 1'b0;
                oe_d   = 1'b1;
                dout_d = cmd_d;
            end
            S_CMD_WR_LOW: begin
                cs_d   = 1'b0;
                rs_d   = 1'b0;
                wr_d   = 1'b0;
                oe_d   = 1'b1;
                dout_d = cmd_d;
            end
            S_TURN, S_RD_HIGH: begin
                cs_d = 1'b0;
            end
            S_RD_LOW: begin
                cs_d = 1'b0;
                rd_d = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // State and output registers; reset releases CS and the bus at once
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            cyc_q      <= '0;
            len_q      <= '0;
            rd_cnt_q   <= '0;
            cmd_q      <= '0;
            cs_q       <= 1'b1;
            rs_q       <= 1'b1;
            wr_q       <= 1'b1;
            rd_q       <= 1'b1;
            oe_q       <= 1'b0;
            dout_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            len_q      <= len_d;
            rd_cnt_q   <= rd_cnt_d;
            cmd_q      <= cmd_d;
            cs_q       <= cs_d;
            rs_q       <= rs_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            oe_q       <= oe_d;
            dout_q     <= dout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign LCD_CS      = cs_q;
    assign LCD_RS      = rs_q;
    assign LCD_WR      = wr_q;
    assign LCD_RD      = rd_q;
    assign LCD_DATA_OE = oe_q;
    assign LCD_DATA_O  = dout_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;

endmodule

// File: doc/lcd_reg_reader.md
Name: lcd_reg_reader

Overview:
- Read-side counterpart of the LCD init/write path.
- Issues one 8080-style command write (RS=0), then N parallel-bus read cycles (RS=1, RD strobed) to read controller registers such as the ID (0xD3) or status.
- Captured words are streamed out with a one-cycle valid strobe.
- Sits beside the LCD init/frame writers. An external mux selects which block drives CS/RS/WR/RD/DATA. The data bus is split into DATA_O, DATA_I and OE; the tristate lives at top level.

Parameters:
- WR_LOW_CYC, 2, cycles WR held low during the command write (min 1)
- WR_HIGH_CYC, 2, cycles WR held high after its rising edge (min 1)
- TURN_CYC, 2, bus turnaround cycles with OE=0 before the first RD (min 1)
- RD_LOW_CYC, 4, cycles RD held low per read (min 2)
- RD_HIGH_CYC, 4, cycles RD held high between reads (min 1)
- LEN_W, 4, width of rd_len

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- req  in  1  start pulse; sampled only in IDLE
- cmd  in  16  command word driven with RS=0
- rd_len  in  LEN_W  number of bus read cycles after the command (0 = command only)
- busy  out  1  high from the cycle after req acceptance through FINISH
- done  out  1  one-cycle pulse in FINISH
- rd_valid  out  1  one-cycle pulse per reported word
- rd_data  out  16  captured word; held until the next capture
- LCD_CS  out  1  chip select, active low
- LCD_RS  out  1  0 = command, 1 = data
- LCD_WR  out  1  write strobe, active low
- LCD_RD  out  1  read strobe, active low
- LCD_DATA_O  out  16  bus drive value
- LCD_DATA_OE  out  1  1 = drive bus
- LCD_DATA_I  in  16  bus sample value

Behaviour:
- Reset (async, rstn=0):
  - LCD_CS=1, LCD_WR=1, LCD_RD=1, LCD_RS=1, LCD_DATA_OE=0, LCD_DATA_O=0.
  - busy=0, done=0, rd_valid=0, rd_data=0, state=IDLE.
  - Reset mid-transaction releases CS and the bus immediately; no completion pulse.
- All outputs are registered.
- On req=1 in IDLE: latch cmd and rd_len, go to CMD_SETUP. req while busy is ignored (not queued).
- CMD_SETUP (1 cycle): CS=0, RS=0, OE=1, DATA_O=cmd, WR=1.
- CMD_WR_LOW (WR_LOW_CYC cycles): WR=0. Data and RS stable.
- CMD_WR_HIGH (WR_HIGH_CYC cycles): WR=1, data still driven.
  - If latched rd_len==0, go to FINISH; otherwise go to TURN.
- TURN (TURN_CYC cycles): OE=0, RS=1, CS=0, WR=1, RD=1.
- RD_LOW (RD_LOW_CYC cycles): RD=0.
  - LCD_DATA_I is registered into rd_data on the last RD_LOW cycle.
  - The next cycle RD returns to 1 and rd_valid=1 for that cycle.
- RD_HIGH (RD_HIGH_CYC cycles): RD=1. Read counter increments.
  - If count < rd_len, go to RD_LOW; otherwise go to FINISH.
- FINISH (1 cycle): CS=1, RS=1, OE=0, done=1, busy=1. Next state IDLE, where busy=0.
- Read counter is LEN_W bits wide. Maximum rd_len is 2^LEN_W-1; no wrap occurs because the count is compared before increment.
- Total busy cycles = 1 + WR_LOW_CYC + WR_HIGH_CYC + FINISH(1), plus TURN_CYC + rd_len*(RD_LOW_CYC+RD_HIGH_CYC) when rd_len>0.
  - Defaults, rd_len=4: 40 cycles.
  - Defaults, rd_len=0: 6 cycles.
- WR and RD are never low in the same cycle. OE is never 1 while RD=0.

Optional Feature:
- Macro: LCD_RD_DUMMY_SKIP_EN.
- Defined: the first bus read after the command is performed with full timing, but its rd_valid pulse is suppressed and rd_data is not updated. rd_len still counts total bus reads, so rd_len=4 yields 3 reported words (ILI93xx dummy-read convention).
- Undefined: every bus read is reported.

Test Plan:
- Reset: hold rstn=0 mid-RD_LOW -> CS=1, RD=1, OE=0, busy=0 in the same cycle; no done pulse after release.
- ID read, defaults, macro off: req, cmd=0x00D3, rd_len=4; model returns 0x0000, 0x0000, 0x0093, 0x0041 -> exactly 4 rd_valid pulses with those values in order; WR low exactly 2 cycles; each RD low exactly 4 cycles; done at cycle 40 after acceptance.
- Same read with LCD_RD_DUMMY_SKIP_EN -> 4 RD pulses, 3 rd_valid pulses: 0x0000, 0x0093, 0x0041.
- Command only: cmd=0x0029, rd_len=0 -> one WR pulse with RS=0 and DATA_O=0x0029; no RD pulse; done 6 cycles after acceptance.
- Busy rejection: second req with cmd=0x0004 during a transfer -> ignored; only the first cmd appears on DATA_O.
- Bus contention check across all runs -> OE=0 whenever RD=0; OE=0 for at least TURN_CYC cycles before the first RD falling edge.
